// File: rtl/db9_md_scanner.sv
// ----------------------------------------------------------------------------
// db9_md_scanner
//
// Sequencer for a shared DB9 user-port joystick interface carrying two Sega
// Megadrive pads on one 6-bit active-low input bus. The block walks the
// 3/6-button select protocol for player 1 and then player 2, decodes the
// returned pins and commits one active-high button vector per player.
//
// Parameters
//   CLK_DIV    clk cycles per protocol step (>= 4 so the synchroniser settles
//              well inside one step)
//   GAP_STEPS  idle steps with mdsel high after the P2 scan, long enough for
//              6-button pads to reset their internal select counter
//
// Ports
//   clk          in   system clock
//   RESET_N      in   asynchronous active-low reset
//   en           in   scan enable; low clears all results and parks in GAP
//   joy_in       in   raw pins, active-low: [0]U/Z [1]D/Y [2]L/X [3]R/Mode
//                     [4]B/A [5]C/Start
//   joy_split    out  player select: 0=P1, 1=P2
//   joy_mdsel    out  Megadrive select line
//   joystick1    out  P1 active-high: [0]R [1]L [2]D [3]U [4]B [5]C [6]A
//                     [7]Start [8]Mode [9]X [10]Y [11]Z, [15:12]=0
//   joystick2    out  P2, same layout
//   pad_present  out  [p] pad p detected in last committed scan
//   pad_six      out  [p] pad p is 6-button
//   frame_done   out  1-cycle pulse, high with the freshly committed P2 result
// ----------------------------------------------------------------------------
module db9_md_scanner #(
    parameter int unsigned CLK_DIV   = 320,
    parameter int unsigned GAP_STEPS = 300
) (
    input  logic        clk,
    input  logic        RESET_N,
    input  logic        en,
    input  logic [5:0]  joy_in,
    output logic        joy_split,
    output logic        joy_mdsel,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic [1:0]  pad_present,
    output logic [1:0]  pad_six,
    output logic        frame_done
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GapW = (GAP_STEPS > 1) ? $clog2(GAP_STEPS) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_STEPS - 1);

    typedef enum logic [1:0] {
        StGap,
        StScan0,
        StSwitch,
        StScan1
    } state_e;

    // ------------------------------------------------------------------------
    // Input synchroniser. Idle pins read high, so reset to all-ones.
    // ------------------------------------------------------------------------
    logic [5:0] sync1_q;
    logic [5:0] sync2_q;

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= joy_in;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------------
    state_e          state_q;
    logic [DivW-1:0] div_q;
    logic [GapW-1:0] gap_cnt_q;
    logic [2:0]      step_q;
    logic            split_q;
    logic            mdsel_q;
    logic            frame_done_q;

    // Per-scan scratch latches, only ever exposed through the s7 commit.
    logic [5:0]      base_q;     // {C,B,U,D,L,R} active-high
    logic [1:0]      as_q;       // {Start,A}
    logic            present_q;
    logic            six_q;
    logic [3:0]      ext_q;      // {Z,Y,X,Mode}

    logic [15:0]     joy1_q;
    logic [15:0]     joy2_q;
    logic [1:0]      present_out_q;
    logic [1:0]      six_out_q;

    logic            tick;
    logic [15:0]     scan_vec;
    logic            scan_six;

    assign tick = (div_q == DivLast);

    // A missing pad commits all-zero; a 3-button pad never reports X/Y/Z/Mode.
    assign scan_vec = present_q ? {4'b0000, (six_q ? ext_q : 4'b0000), as_q, base_q} : 16'h0000;
    assign scan_six = present_q & six_q;

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= StGap;
            div_q         <= '0;
            gap_cnt_q     <= '0;
            step_q        <= 3'd0;
            split_q       <= 1'b0;
            mdsel_q       <= 1'b1;
            frame_done_q  <= 1'b0;
            base_q        <= '0;
            as_q          <= '0;
            present_q     <= 1'b0;
            six_q         <= 1'b0;
            ext_q         <= '0;
            joy1_q        <= '0;
            joy2_q        <= '0;
            present_out_q <= '0;
            six_out_q     <= '0;
        end else if (!en) begin
            // Disable takes priority over anything the scan would do this cycle,
            // including a commit on the final step.
            state_q       <= StGap;
            div_q         <= '0;
            gap_cnt_q     <= '0;
            step_q        <= 3'd0;
            split_q       <= 1'b0;
            mdsel_q       <= 1'b1;
            frame_done_q  <= 1'b0;
            base_q        <= '0;
            as_q          <= '0;
            present_q     <= 1'b0;
            six_q         <= 1'b0;
            ext_q         <= '0;
            joy1_q        <= '0;
            joy2_q        <= '0;
            present_out_q <= '0;
            six_out_q     <= '0;
        end else begin
            frame_done_q <= 1'b0;
            div_q        <= tick ? '0 : div_q + 1'b1;

            if (tick) begin
                unique case (state_q)
                    StGap: begin
                        if (gap_cnt_q == GapLast) begin
                            state_q   <= StScan0;
                            gap_cnt_q <= '0;
                            step_q    <= 3'd0;
                            split_q   <= 1'b0;
                            mdsel_q   <= 1'b1;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + 1'b1;
                        end
                    end

                    StSwitch: begin
                        state_q <= StScan1;
                        step_q  <= 3'd0;
                        split_q <= 1'b1;
                        mdsel_q <= 1'b1;
                    end

                    StScan0, StScan1: begin
                        // Samples are taken at the end of the step, after the
                        // pad has answered the select level set at its start.
                        case (step_q)
                            3'd0: base_q <= {~sync2_q[5], ~sync2_q[4], ~sync2_q[0],
                                             ~sync2_q[1], ~sync2_q[2], ~sync2_q[3]};
                            3'd1: begin
                                as_q      <= {~sync2_q[5], ~sync2_q[4]};
                                // Any Megadrive pad grounds L and R while select is low.
                                present_q <= (sync2_q[3:2] == 2'b00);
                            end
                            // Third select-low: a 6-button pad grounds all four directions.
                            3'd5: six_q <= (sync2_q[3:0] == 4'b0000);
                            3'd6: begin
                                if (six_q) begin
                                    ext_q <= {~sync2_q[0], ~sync2_q[1], ~sync2_q[2], ~sync2_q[3]};
                                end
                            end
                            default: ;
                        endcase

                        if (step_q == 3'd7) begin
                            mdsel_q <= 1'b1;
                            if (state_q == StScan0) begin
                                joy1_q           <= scan_vec;
                                present_out_q[0] <= present_q;
                                six_out_q[0]     <= scan_six;
                                state_q          <= StSwitch;
                                split_q          <= 1'b1;
                            end else begin
                                joy2_q           <= scan_vec;
                                present_out_q[1] <= present_q;
                                six_out_q[1]     <= scan_six;
                                frame_done_q     <= 1'b1;
                                state_q          <= StGap;
                                gap_cnt_q        <= '0;
                                split_q          <= 1'b0;
                            end
                        end else begin
                            step_q  <= step_q + 3'd1;
                            // Step s+1 is even (select high) exactly when s is odd.
                            mdsel_q <= step_q[0];
                        end
                    end

                    default: state_q <= StGap;
                endcase
            end
        end
    end

    assign joy_split   = split_q;
    assign joy_mdsel   = mdsel_q;
    assign joystick1   = joy1_q;
    assign joystick2   = joy2_q;
    assign pad_present = present_out_q;
    assign pad_six     = six_out_q;
    assign frame_done  = frame_done_q;

endmodule
